spi_master: RTL

SPI mode-0 master, the controller-side counterpart of the FPGA-side SPI slave. It frames one transfer under an active-low SSEL and shifts a FRAME_BITS-wide command/data word out on MOSI, MSB first. During the same frame it captures the first RX_BITS bits returned on MISO, such as the 40-bit humidity record. SCK is divided down from clk so that a slave which oversamples SCK/SSEL/MOSI through 2–3 flop synchronisers on its own clk sees clean edges.

---
 rtl/spi_master.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: one SSEL-framed transfer of FRAME_BITS on MOSI, MSB first, capturing the first RX_BITS of MISO.
// Optional build macro SPI_MASTER_LOOPBACK_EN feeds MOSI back as the MISO source for board bring-up.
module spi_master #(
    parameter int FRAME_BITS = 88,
    parameter int RX_BITS    = 40,
    parameter int CLK_DIV    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [RX_BITS-1:0]    rx_data,
    output logic                  SCK,
    output logic                  SSEL,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W:0]   RX_LIMIT = (BIT_W + 1)'(RX_BITS);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;

    state_t                r_state, w_state_next;
    logic [DIV_W-1:0]      r_divcnt, w_divcnt_next;
    logic [BIT_W-1:0]      r_bitcnt, w_bitcnt_next;
    logic [FRAME_BITS-1:0] r_shift_tx, w_shift_tx_next, w_tx_shifted;
    logic [RX_BITS-1:0]    r_shift_rx, w_shift_rx_next;
    logic [RX_BITS-1:0]    r_rx_data, w_rx_data_next;
    logic                  r_sck, w_sck_next;
    logic                  r_ssel, w_ssel_next;
    logic                  r_mosi, w_mosi_next;
    logic                  r_busy, w_busy_next;
    logic                  r_done, w_done_next;
    logic                  w_div_last, w_bit_last, w_rx_want;
    logic                  w_miso_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic w_unused_miso;
    assign w_unused_miso = MISO;
    assign w_miso_bit    = r_mosi;
`else
    logic r_miso_meta, r_miso_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= MISO;
            r_miso_sync <= r_miso_meta;
        end
    end

    assign w_miso_bit = r_miso_sync;
`endif

    assign w_div_last   = (r_divcnt == DIV_LAST);
    assign w_bit_last   = (r_bitcnt == BIT_LAST);
    assign w_rx_want    = ({1'b0, r_bitcnt} < RX_LIMIT);
    assign w_tx_shifted = r_shift_tx << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_divcnt   <= '0;
            r_bitcnt   <= '0;
            r_shift_tx <= '0;
            r_shift_rx <= '0;
            r_rx_data  <= '0;
            r_sck      <= 1'b0;
            r_ssel     <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_divcnt   <= w_divcnt_next;
            r_bitcnt   <= w_bitcnt_next;
            r_shift_tx <= w_shift_tx_next;
            r_shift_rx <= w_shift_rx_next;
            r_rx_data  <= w_rx_data_next;
            r_sck      <= w_sck_next;
            r_ssel     <= w_ssel_next;
            r_mosi     <= w_mosi_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    // Divider restarts on every state change so each phase is exactly CLK_DIV cycles.
    always_comb begin
        w_state_next  = r_state;
        w_divcnt_next = w_div_last ? '0 : r_divcnt + 1'b1;
        w_bitcnt_next = r_bitcnt;
        case (r_state)
            S_IDLE: begin
                w_divcnt_next = '0;
                w_bitcnt_next = '0;
                if (start) w_state_next = S_SETUP;
            end
            S_SETUP: if (w_div_last) w_state_next = S_HIGH;
            S_HIGH:  if (w_div_last) w_state_next = S_LOW;
            S_LOW: begin
                if (w_div_last) begin
                    if (w_bit_last) begin
                        w_state_next = S_GAP;
                    end else begin
                        w_state_next  = S_HIGH;
                        w_bitcnt_next = r_bitcnt + 1'b1;
                    end
                end
            end
            S_GAP:   if (w_div_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_shift_tx_next = r_shift_tx;
        w_shift_rx_next = r_shift_rx;
        w_rx_data_next  = r_rx_data;
        w_sck_next      = r_sck;
        w_ssel_next     = r_ssel;
        w_mosi_next     = r_mosi;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shift_tx_next = tx_data;
                    w_ssel_next     = 1'b0;
                    w_mosi_next     = tx_data[FRAME_BITS-1];
                    w_busy_next     = 1'b1;
                end
            end
            S_SETUP: if (w_div_last) w_sck_next = 1'b1;
            S_HIGH: begin
                // First cycle of the high phase: MISO has settled since the previous fall.
                if (r_divcnt == '0 && w_rx_want)
                    w_shift_rx_next = RX_BITS'({r_shift_rx, w_miso_bit});
                if (w_div_last) begin
                    w_sck_next = 1'b0;
                    if (!w_bit_last) begin
                        w_shift_tx_next = w_tx_shifted;
                        w_mosi_next     = w_tx_shifted[FRAME_BITS-1];
                    end
                end
            end
            S_LOW: begin
                if (w_div_last) begin
                    if (w_bit_last) begin
                        w_ssel_next    = 1'b1;
                        w_rx_data_next = r_shift_rx;
                        w_done_next    = 1'b1;
                    end else begin
                        w_sck_next = 1'b1;
                    end
                end
            end
            S_GAP:   if (w_div_last) w_busy_next = 1'b0;
            default: ;
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign SCK     = r_sck;
    assign SSEL    = r_ssel;
    assign MOSI    = r_mosi;

endmodule
